// File: rtl/rpn_stack_sequencer_pkg.sv
// Shared types and constants for the RPN stack sequencer: FSM states,
// error causes, opcode type and the ALU timeout limit.
package rpn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ALU  = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_ERROR     = 3'd4
  } state_t;

  typedef logic [1:0] opcode_t;
  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE = 2'd0;
  localparam err_code_t ERR_OVF  = 2'd1;
  localparam err_code_t ERR_UNF  = 2'd2;
  localparam err_code_t ERR_TMO  = 2'd3;

  localparam int TIMEOUT_LIMIT = 16;

endpackage

// File: rtl/rpn_stack_regfile.sv
// Operand stack storage: DEPTH x WIDTH registers, one write port and two
// read ports addressed by the current entry count (top and second-from-top).
module rpn_stack_regfile #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_we,
  input  logic [DW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [DW-1:0]    i_depth,
  output logic [WIDTH-1:0] o_top,
  output logic [WIDTH-1:0] o_next
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!reset_n) begin
        r_mem[i] <= '0;
      end else if (i_we && int'(i_waddr) == i) begin
        r_mem[i] <= i_wdata;
      end
    end
  end

  // Compared as int so depth+1 never wraps for small DEPTH; empty slots read 0.
  always_comb begin
    o_top  = '0;
    o_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(i_depth) == i + 1) o_top  = r_mem[i];
      if (int'(i_depth) == i + 2) o_next = r_mem[i];
    end
  end

endmodule

// File: rtl/rpn_stack_sequencer.sv
// RPN operand stack sequencer: pushes operands, hands the top two entries to
// an external ALU, writes the result back and reports overflow/underflow/timeout.
module rpn_stack_sequencer
  import rpn_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push_pulse,
  input  logic             op_pulse,
  input  logic             clear_pulse,
  input  logic [WIDTH-1:0] data_in,
  input  opcode_t          opcode_in,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output opcode_t          alu_opcode,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] top_value,
  output logic [DW-1:0]    depth,
  output logic             busy,
  output logic [2:0]       status,
  output err_code_t        err_code
);

  localparam int TW = $clog2(TIMEOUT_LIMIT);

  state_t           r_state;
  logic [DW-1:0]    r_depth;
  err_code_t        r_err;
  logic [TW-1:0]    r_tmo;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  opcode_t          r_opcode;
  logic [WIDTH-1:0] r_result;

  state_t           w_next_state;
  logic [DW-1:0]    w_depth_next;
  err_code_t        w_err_next;
  logic [TW-1:0]    w_tmo_next;
  logic             w_we;
  logic [DW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic             w_latch_op;
  logic             w_capture;
  logic [WIDTH-1:0] w_rd_top;
  logic [WIDTH-1:0] w_rd_next;

  rpn_stack_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DW(DW)) u_regfile (
    .clock   (clock),
    .reset_n (reset_n),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_depth (r_depth),
    .o_top   (w_rd_top),
    .o_next  (w_rd_next)
  );

  always_comb begin
    w_next_state = r_state;
    w_depth_next = r_depth;
    w_err_next   = r_err;
    w_tmo_next   = '0;
    w_we         = 1'b0;
    w_waddr      = r_depth;
    w_wdata      = data_in;
    w_latch_op   = 1'b0;
    w_capture    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (op_pulse) begin
          if (r_depth >= DW'(2)) begin
            w_latch_op   = 1'b1;
            w_next_state = ST_ISSUE;
          end else begin
            w_err_next   = ERR_UNF;
            w_next_state = ST_ERROR;
          end
        end else if (push_pulse) begin
          if (r_depth < DW'(DEPTH)) begin
            w_we         = 1'b1;
            w_depth_next = r_depth + DW'(1);
          end else begin
            w_err_next   = ERR_OVF;
            w_next_state = ST_ERROR;
          end
        end
      end
      ST_ISSUE: w_next_state = ST_WAIT_ALU;
      ST_WAIT_ALU: begin
        if (alu_done) begin
          w_capture    = 1'b1;
          w_next_state = ST_WRITEBACK;
        end else if (r_tmo == TW'(TIMEOUT_LIMIT - 1)) begin
          w_err_next   = ERR_TMO;
          w_next_state = ST_ERROR;
        end else begin
          w_tmo_next = r_tmo + TW'(1);
        end
      end
      ST_WRITEBACK: begin
        w_we         = 1'b1;
        w_waddr      = r_depth - DW'(2);
        w_wdata      = r_result;
        w_depth_next = r_depth - DW'(1);
        w_next_state = ST_IDLE;
      end
      ST_ERROR: w_next_state = ST_ERROR;
      default:  w_next_state = ST_IDLE;
    endcase
    // Clear wins from every state and drops any in-flight operation.
    if (clear_pulse) begin
      w_next_state = ST_IDLE;
      w_depth_next = '0;
      w_err_next   = ERR_NONE;
      w_tmo_next   = '0;
      w_we         = 1'b0;
      w_latch_op   = 1'b0;
      w_capture    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_depth  <= '0;
      r_err    <= ERR_NONE;
      r_tmo    <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_opcode <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next_state;
      r_depth <= w_depth_next;
      r_err   <= w_err_next;
      r_tmo   <= w_tmo_next;
      if (w_latch_op) begin
        r_alu_a  <= w_rd_next;
        r_alu_b  <= w_rd_top;
        r_opcode <= opcode_in;
      end
      if (w_capture) r_result <= alu_result;
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_opcode = r_opcode;
  assign alu_start  = (r_state == ST_ISSUE);
  assign top_value  = w_rd_top;
  assign depth      = r_depth;
  assign busy       = (r_state == ST_ISSUE) || (r_state == ST_WAIT_ALU) ||
                      (r_state == ST_WRITEBACK);
  assign status     = r_state;
  assign err_code   = r_err;

endmodule

// File: tb/tb_rpn_stack_sequencer.sv
// Self-checking bench for rpn_stack_sequencer: directed scenarios plus a
// randomized run compared against a queue-based model of the operand stack.
module tb_rpn_stack_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        push_pulse;
  logic        op_pulse;
  logic        clear_pulse;
  logic [15:0] data_in;
  logic [1:0]  opcode_in;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [1:0]  alu_opcode;
  logic        alu_start;
  logic        alu_done;
  logic [15:0] alu_result;
  logic [15:0] top_value;
  logic [2:0]  depth;
  logic        busy;
  logic [2:0]  status;
  logic [1:0]  err_code;

  int checkCount = 0;
  int errorCount = 0;

  logic [15:0] mStack[$];
  int          mErr = 0;

  rpn_stack_sequencer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .push_pulse  (push_pulse),
    .op_pulse    (op_pulse),
    .clear_pulse (clear_pulse),
    .data_in     (data_in),
    .opcode_in   (opcode_in),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_opcode  (alu_opcode),
    .alu_start   (alu_start),
    .alu_done    (alu_done),
    .alu_result  (alu_result),
    .top_value   (top_value),
    .depth       (depth),
    .busy        (busy),
    .status      (status),
    .err_code    (err_code)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of requests; the DUT samples them on the next rising edge.
  task automatic applyStimulus(input logic push, input logic op, input logic clr,
                               input logic [15:0] data, input logic [1:0] opc);
    push_pulse  = push;
    op_pulse    = op;
    clear_pulse = clr;
    data_in     = data;
    opcode_in   = opc;
    @(posedge clock);
    #1;
    push_pulse  = 1'b0;
    op_pulse    = 1'b0;
    clear_pulse = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 2'd0);
  endtask

  function automatic logic [15:0] aluFn(input logic [1:0] opc, input logic [15:0] a,
                                        input logic [15:0] b);
    case (opc)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic void modelPush(input logic [15:0] d);
    if (mErr != 0) return;
    if (mStack.size() == 4) mErr = 1;
    else mStack.push_back(d);
  endfunction

  function automatic void modelClear();
    mStack.delete();
    mErr = 0;
  endfunction

  task automatic checkState(input string tag);
    checkOutput({tag, "_depth"}, 32'(depth), 32'(mStack.size()));
    checkOutput({tag, "_top"}, 32'(top_value),
                (mStack.size() == 0) ? 32'd0 : 32'(mStack[$]));
    checkOutput({tag, "_status"}, 32'(status), (mErr != 0) ? 32'd4 : 32'd0);
    checkOutput({tag, "_err"}, 32'(err_code), 32'(mErr));
  endtask

  // Full legal operation: issue, ALU answers after 'latency' WAIT cycles, writeback.
  task automatic runOp(input string tag, input logic [1:0] opc, input int latency,
                       input logic alsoPush, input logic [15:0] pushData);
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    a = mStack[$-1];
    b = mStack[$];
    r = aluFn(opc, a, b);
    applyStimulus(alsoPush, 1'b1, 1'b0, pushData, opc);
    checkOutput({tag, "_start"}, 32'(alu_start), 32'd1);
    checkOutput({tag, "_a"}, 32'(alu_a), 32'(a));
    checkOutput({tag, "_b"}, 32'(alu_b), 32'(b));
    checkOutput({tag, "_opc"}, 32'(alu_opcode), 32'(opc));
    checkOutput({tag, "_issue"}, 32'(status), 32'd1);
    idleCycle();
    checkOutput({tag, "_start_low"}, 32'(alu_start), 32'd0);
    checkOutput({tag, "_wait"}, 32'(status), 32'd2);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    for (int k = 1; k < latency; k++) idleCycle();
    alu_done   = 1'b1;
    alu_result = r;
    idleCycle();
    alu_done   = 1'b0;
    alu_result = 16'($urandom);
    checkOutput({tag, "_wb"}, 32'(status), 32'd3);
    checkOutput({tag, "_a_hold"}, 32'(alu_a), 32'(a));
    idleCycle();
    void'(mStack.pop_back());
    void'(mStack.pop_back());
    mStack.push_back(r);
    checkState(tag);
  endtask

  initial begin
    int          sel;
    logic [15:0] d;
    logic [1:0]  opc;

    reset_n     = 1'b0;
    push_pulse  = 1'b0;
    op_pulse    = 1'b0;
    clear_pulse = 1'b0;
    data_in     = 16'h0;
    opcode_in   = 2'd0;
    alu_done    = 1'b0;
    alu_result  = 16'h0;
    repeat (2) @(posedge clock);
    #1;
    checkState("reset");
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_start", 32'(alu_start), 32'd0);
    checkOutput("reset_a", 32'(alu_a), 32'd0);
    reset_n = 1'b1;

    $display("[TB] basic add");
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd5, 2'd0); modelPush(16'd5);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd7, 2'd0); modelPush(16'd7);
    checkState("push57");
    runOp("add57", 2'd0, 1, 1'b0, 16'h0);
    checkOutput("add57_result", 32'(top_value), 32'd12);

    $display("[TB] overflow");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 2'd0); modelClear();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'(i), 2'd0);
      modelPush(16'(i));
    end
    checkState("full");
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd9, 2'd0); modelPush(16'd9);
    checkState("ovf");
    checkOutput("ovf_code", 32'(err_code), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 2'd0); modelClear();
    checkState("ovf_clear");

    $display("[TB] underflow");
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd33, 2'd0); modelPush(16'd33);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 2'd1); mErr = 2;
    checkState("unf");
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd44, 2'd0); modelPush(16'd44);
    checkState("unf_push_ignored");

    $display("[TB] timeout");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 2'd0); modelClear();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd10, 2'd0); modelPush(16'd10);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd20, 2'd0); modelPush(16'd20);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 2'd2);
    idleCycle();
    for (int k = 0; k < 15; k++) idleCycle();
    checkOutput("tmo_still_wait", 32'(status), 32'd2);
    idleCycle(); mErr = 3;
    checkState("tmo");
    alu_done = 1'b1; alu_result = 16'hBEEF;
    idleCycle();
    alu_done = 1'b0;
    checkState("tmo_late_done");

    $display("[TB] push and op together");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 2'd0); modelClear();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd100, 2'd0); modelPush(16'd100);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd30, 2'd0); modelPush(16'd30);
    runOp("pushop", 2'd1, 2, 1'b1, 16'd99);

    $display("[TB] clear during WAIT_ALU");
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd6, 2'd0); modelPush(16'd6);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 2'd3);
    idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 2'd0); modelClear();
    checkState("clr_wait");
    alu_done = 1'b1; alu_result = 16'h5555;
    idleCycle();
    alu_done = 1'b0;
    checkState("clr_wait_late_done");

    $display("[TB] reset during WAIT_ALU");
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd3, 2'd0); modelPush(16'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd4, 2'd0); modelPush(16'd4);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 2'd2);
    idleCycle();
    checkOutput("rst_pre_wait", 32'(status), 32'd2);
    reset_n = 1'b0;
    idleCycle();
    modelClear();
    checkState("rst_wait");
    checkOutput("rst_a", 32'(alu_a), 32'd0);
    checkOutput("rst_b", 32'(alu_b), 32'd0);
    checkOutput("rst_opc", 32'(alu_opcode), 32'd0);
    checkOutput("rst_start", 32'(alu_start), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    alu_done = 1'b1; alu_result = 16'h7777;
    idleCycle();
    alu_done = 1'b0;
    checkState("rst_late_done");

    $display("[TB] randomized run");
    for (int it = 0; it < 80; it++) begin
      sel = int'($urandom_range(0, 9));
      d   = 16'($urandom);
      opc = 2'($urandom);
      if (sel == 0) begin
        applyStimulus(1'b0, 1'b0, 1'b1, d, opc);
        modelClear();
        checkState("rnd_clear");
      end else if (sel <= 4) begin
        applyStimulus(1'b1, 1'b0, 1'b0, d, opc);
        modelPush(d);
        checkState("rnd_push");
      end else if (mErr == 0 && mStack.size() >= 2) begin
        runOp("rnd_op", opc, int'($urandom_range(1, 6)), sel == 9, d);
      end else begin
        applyStimulus(sel == 9, 1'b1, 1'b0, d, opc);
        if (mErr == 0) mErr = 2;
        checkState("rnd_bad_op");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/rpn_stack_sequencer.md
RPN_STACK_SEQUENCER -- requirements
Module: rpn_stack_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set operand/result bit width.
REQ-002 Parameter DEPTH, default 4, SHALL set operand stack entries; DW = clog2(DEPTH+1).
REQ-003 Port clock, in, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset_n, in, 1: synchronous, active-low reset.
REQ-005 Port push_pulse, in, 1: one-cycle request to push data_in.
REQ-006 Port op_pulse, in, 1: one-cycle request to apply opcode_in to the top two entries.
REQ-007 Port clear_pulse, in, 1: one-cycle request to empty the stack and clear errors.
REQ-008 Port data_in, in, WIDTH: operand to push.
REQ-009 Port opcode_in, in, 2: ALU operation code, passed through unmodified.
REQ-010 Ports alu_a/alu_b, out, WIDTH each: ALU operands (second-from-top / top).
REQ-011 Ports alu_opcode (out, 2), alu_start (out, 1): latched opcode; one-cycle start strobe.
REQ-012 Ports alu_done (in, 1), alu_result (in, WIDTH): ALU completion strobe and result.
REQ-013 Ports top_value (out, WIDTH), depth (out, DW): top entry (0 when empty) and entry count.
REQ-014 Ports busy (out, 1), status (out, 3), err_code (out, 2): state visibility and error cause.

Function
REQ-015 FSM states SHALL be IDLE(status 0), ISSUE(1), WAIT_ALU(2), WRITEBACK(3), ERROR(4); busy=1 in ISSUE, WAIT_ALU, WRITEBACK.
REQ-016 IDLE request priority SHALL be clear_pulse > op_pulse > push_pulse; a lower-priority pulse in the same cycle is discarded.
REQ-017 IDLE push with depth<DEPTH: stack[depth]<=data_in, depth+1, next cycle; stay in IDLE.
REQ-018 IDLE push with depth==DEPTH: stack unchanged, err_code<=1 (overflow), next state ERROR.
REQ-019 IDLE op with depth>=2: latch alu_a=stack[depth-2], alu_b=stack[depth-1], alu_opcode=opcode_in; go to ISSUE.
REQ-020 IDLE op with depth<2: stack unchanged, err_code<=2 (underflow), next state ERROR.
REQ-021 ISSUE SHALL assert alu_start for exactly one cycle, then go to WAIT_ALU; alu_a/alu_b/alu_opcode held stable from ISSUE until WRITEBACK exit.
REQ-022 WAIT_ALU with alu_done=1: capture alu_result; go to WRITEBACK. alu_done outside WAIT_ALU SHALL be ignored.
REQ-023 WAIT_ALU SHALL count cycles; 16 cycles with no alu_done: err_code<=3 (timeout), next state ERROR, stack unchanged.
REQ-024 WRITEBACK: stack[depth-2]<=captured result, depth-1, next state IDLE; latency op_pulse to updated top_value is 4 cycles with a 1-cycle ALU.
REQ-025 push_pulse/op_pulse while busy or in ERROR SHALL be ignored, with no queuing.
REQ-026 clear_pulse in any state: depth<=0, err_code<=0, alu_start<=0, state IDLE next cycle; an in-flight ALU result is discarded.
REQ-027 ERROR SHALL persist, stack contents preserved, until clear_pulse or reset.
REQ-028 top_value SHALL be combinational from stack[depth-1], or 0 when depth==0.
REQ-029 No arithmetic is performed here; result width is WIDTH, truncation belongs to the ALU.

Reset
REQ-030 reset_n==0 at a clock edge: state IDLE, depth 0, err_code 0, alu_a/alu_b 0, alu_opcode 0, alu_start 0, timeout counter 0.
REQ-031 Stack storage SHALL be reset to 0; reset overrides clear_pulse and any in-flight operation.

Structure
REQ-032 Package rpn_pkg SHALL hold the state enum, the err_code constants (NONE=0, OVF=1, UNF=2, TMO=3), the opcode typedef and the timeout limit 16.
REQ-033 Stack storage SHALL be sub-module rpn_stack_regfile (DEPTH x WIDTH, one write port, two read ports at depth-1 and depth-2).

Verification
REQ-034 Push 5, 7; op_pulse opcode 0; ALU model adds with done after 1 cycle -> alu_start one cycle with a=5, b=7; then depth=1, top_value=12, status returns to 0.
REQ-035 Push 1,2,3,4 then push 9 -> depth stays 4, top_value 4, status 4, err_code 1; clear_pulse -> depth 0, err_code 0, status 0.
REQ-036 One entry pushed; op_pulse -> err_code 2, status 4; a following push_pulse is ignored and depth stays 1.
REQ-037 Valid op with ALU never asserting done -> after 16 WAIT_ALU cycles status 4, err_code 3, depth 2 unchanged.
REQ-038 push_pulse and op_pulse in the same cycle with depth 2 -> op executes and depth is 1 after WRITEBACK; data_in is not pushed. reset_n low in WAIT_ALU -> all outputs 0 next cycle, and a late alu_done has no effect.
